// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg
//
// Shared definitions for the ripple-carry adder slice.
//
//   ADDER_WIDTH_DEFAULT : default operand width (1 -> plain full adder)
//   ADDER_WIDTH_MAX     : widest operand the adder is meant to be built at
//   adder_ref()         : behavioural {cout, s} for a given width, intended
//                         for benches and quick sanity checks elsewhere
//   adder_ovf_ref()     : behavioural signed-overflow flag for a given width
// ----------------------------------------------------------------------------
package adder_pkg;

    localparam int ADDER_WIDTH_DEFAULT = 1;
    localparam int ADDER_WIDTH_MAX     = 64;

    // Returns the full (width+1)-bit result packed as {cout, s} in the low
    // width+1 bits of a 65-bit vector; bits above are zero. Operand bits at
    // and above 'width' are ignored.
    function automatic logic [ADDER_WIDTH_MAX:0] adder_ref(
        input logic [ADDER_WIDTH_MAX-1:0] a,
        input logic [ADDER_WIDTH_MAX-1:0] b,
        input logic                       cin,
        input int                         width
    );
        logic [ADDER_WIDTH_MAX:0] mask;
        logic [ADDER_WIDTH_MAX:0] sum;
        mask = ({{ADDER_WIDTH_MAX{1'b0}}, 1'b1} << width) - 1'b1;
        sum  = ({1'b0, a} & mask) + ({1'b0, b} & mask)
             + {{ADDER_WIDTH_MAX{1'b0}}, cin};
        // Keep the carry at bit 'width', drop anything above it.
        return sum & ((mask << 1) | 65'd1);
    endfunction

    // Signed overflow: both operands share a sign and the sum's sign differs.
    // The carry-in cannot flip this on its own except through that sign
    // change, which is exactly what c[MSB] ^ c[MSB+1] captures in hardware.
    function automatic logic adder_ovf_ref(
        input logic [ADDER_WIDTH_MAX-1:0] a,
        input logic [ADDER_WIDTH_MAX-1:0] b,
        input logic                       cin,
        input int                         width
    );
        logic [ADDER_WIDTH_MAX:0] r;
        r = adder_ref(a, b, cin, width);
        return (a[width-1] == b[width-1]) && (r[width-1] != a[width-1]);
    endfunction

endpackage : adder_pkg

// File: rtl/adder_full_adder_cell.sv
// ----------------------------------------------------------------------------
// full_adder_cell
//
// One bit of the ripple chain.
//
//   a, b : operand bits
//   cin  : carry into this bit
//   s    : sum bit          a ^ b ^ cin
//   cout : carry out        generate | (propagate & cin)
// ----------------------------------------------------------------------------
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic propagate;
    logic generate_bit;

    assign propagate    = a ^ b;
    assign generate_bit = a & b;

    assign s    = propagate ^ cin;
    assign cout = generate_bit | (propagate & cin);

endmodule : full_adder_cell

// File: rtl/adder.sv
// ----------------------------------------------------------------------------
// adder
//
// Parameterised ripple-carry adder: {cout, s} = a + b + cin.
// At WIDTH=1 this is a single full adder.
//
// Parameters
//   WIDTH      operand / sum width, 1..64
//
// Ports
//   clk        rising-edge clock, only used by the registered copy
//   rst        asynchronous reset, ACTIVE LOW (name kept from the codebase)
//   a, b       operands (signedness agnostic)
//   cin        carry-in
//   in_valid   qualifies a/b/cin for the registered copy
//   s          combinational sum, (a+b+cin) mod 2^WIDTH
//   cout       combinational carry-out
//   ovf        combinational signed overflow, c[WIDTH-1] ^ c[WIDTH]
//   s_q        registered sum
//   cout_q     registered carry-out
//   ovf_q      registered overflow
//   out_valid  registered in_valid (one cycle of latency)
//
// The combinational outputs do not depend on clk or rst at all; only the
// registered copy sees the reset.
// ----------------------------------------------------------------------------
module adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH-1:0] s_q,
    output logic             cout_q,
    output logic             ovf_q,
    output logic             out_valid
);

    // ------------------------------------------------------------------
    // Ripple chain. c[i] is the carry INTO bit i; c[0] is the external
    // carry-in and c[WIDTH] is the carry-out of the whole word.
    // ------------------------------------------------------------------
    logic [WIDTH:0] c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            full_adder_cell u_cell (
                .a    (a[gi]),
                .b    (b[gi]),
                .cin  (c[gi]),
                .s    (s[gi]),
                .cout (c[gi+1])
            );
        end
    endgenerate

    assign cout = c[WIDTH];

    // Overflow is the disagreement between the carry into and out of the
    // sign bit. At WIDTH=1 the carry into the sign bit is cin itself.
    assign ovf = c[WIDTH-1] ^ c[WIDTH];

    // ------------------------------------------------------------------
    // Registered copy for pipelined consumers. Result registers only load
    // on a valid input so a bubble keeps the last good result visible;
    // the valid flag follows in_valid every cycle.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] s_q_reg;
    logic             cout_q_reg;
    logic             ovf_q_reg;
    logic             out_valid_reg;

    logic [WIDTH-1:0] s_q_next;
    logic             cout_q_next;
    logic             ovf_q_next;
    logic             out_valid_next;

    always_comb begin
        s_q_next       = s_q_reg;
        cout_q_next    = cout_q_reg;
        ovf_q_next     = ovf_q_reg;
        out_valid_next = in_valid;
        if (in_valid) begin
            s_q_next    = s;
            cout_q_next = cout;
            ovf_q_next  = ovf;
        end
    end

    // rst is low-active and asynchronous on assertion; release is seen at
    // the next rising clk, so the first capture happens on that edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q_reg       <= '0;
            cout_q_reg    <= 1'b0;
            ovf_q_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            s_q_reg       <= s_q_next;
            cout_q_reg    <= cout_q_next;
            ovf_q_reg     <= ovf_q_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign s_q       = s_q_reg;
    assign cout_q    = cout_q_reg;
    assign ovf_q     = ovf_q_reg;
    assign out_valid = out_valid_reg;

endmodule : adder

// File: tb/tb_adder.sv
// ----------------------------------------------------------------------------
// tb_adder
//
// Three instances of adder (WIDTH = 1, 4, 8) on a shared clock and reset.
// Fixed vectors come from a table of {width, inputs, expected} records;
// the registered path and the asynchronous reset get short hand-written
// sequences; WIDTH=8 then runs random traffic against a model built from
// plain integer arithmetic.
// ----------------------------------------------------------------------------
module tb_adder;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // ---------------- WIDTH = 1 ----------------
    logic [0:0] a1 = '0, b1 = '0, s1, s1_q;
    logic       cin1 = 1'b0, iv1 = 1'b0, cout1, ovf1, cout1_q, ovf1_q, ov1;

    adder #(.WIDTH(1)) u_add1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .in_valid(iv1),
        .s(s1), .cout(cout1), .ovf(ovf1),
        .s_q(s1_q), .cout_q(cout1_q), .ovf_q(ovf1_q), .out_valid(ov1)
    );

    // ---------------- WIDTH = 4 ----------------
    logic [3:0] a4 = '0, b4 = '0, s4, s4_q;
    logic       cin4 = 1'b0, iv4 = 1'b0, cout4, ovf4, cout4_q, ovf4_q, ov4;

    adder #(.WIDTH(4)) u_add4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4), .in_valid(iv4),
        .s(s4), .cout(cout4), .ovf(ovf4),
        .s_q(s4_q), .cout_q(cout4_q), .ovf_q(ovf4_q), .out_valid(ov4)
    );

    // ---------------- WIDTH = 8 ----------------
    logic [7:0] a8 = '0, b8 = '0, s8, s8_q;
    logic       cin8 = 1'b0, iv8 = 1'b0, cout8, ovf8, cout8_q, ovf8_q, ov8;

    adder #(.WIDTH(8)) u_add8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .in_valid(iv8),
        .s(s8), .cout(cout8), .ovf(ovf8),
        .s_q(s8_q), .cout_q(cout8_q), .ovf_q(ovf8_q), .out_valid(ov8)
    );

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Unsigned sum as a plain integer; bit w of it is the carry-out.
    function automatic int unsigned ref_total(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned cin);
        return a + b + cin;
    endfunction

    // Signed overflow: interpret operands as w-bit two's complement and see
    // whether the true result falls outside the representable range.
    function automatic logic ref_ovf(input int unsigned a, input int unsigned b,
                                     input int unsigned cin, input int w);
        int sa, sb, sum, lo, hi;
        sa  = (a >= (1 << (w - 1))) ? int'(a) - (1 << w) : int'(a);
        sb  = (b >= (1 << (w - 1))) ? int'(b) - (1 << w) : int'(b);
        sum = sa + sb + int'(cin);
        lo  = -(1 << (w - 1));
        hi  = (1 << (w - 1)) - 1;
        return (sum < lo) || (sum > hi);
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        int         w;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int unsigned ta, tb, tc, tot;
        logic [7:0]  exp_s8_q;
        logic        exp_c8_q, exp_o8_q, exp_v8;
        logic        nxt_iv;

        // Full-adder truth table, then the two WIDTH=4 boundary vectors.
        vecs[0] = '{1, 8'h0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b0};
        vecs[1] = '{1, 8'h0, 8'h0, 1'b1, 8'h1, 1'b0, 1'b1};
        vecs[2] = '{1, 8'h0, 8'h1, 1'b0, 8'h1, 1'b0, 1'b0};
        vecs[3] = '{1, 8'h0, 8'h1, 1'b1, 8'h0, 1'b1, 1'b0};
        vecs[4] = '{1, 8'h1, 8'h0, 1'b0, 8'h1, 1'b0, 1'b0};
        vecs[5] = '{1, 8'h1, 8'h0, 1'b1, 8'h0, 1'b1, 1'b0};
        vecs[6] = '{1, 8'h1, 8'h1, 1'b0, 8'h0, 1'b1, 1'b1};
        vecs[7] = '{1, 8'h1, 8'h1, 1'b1, 8'h1, 1'b1, 1'b0};
        vecs[8] = '{4, 8'hF, 8'h0, 1'b1, 8'h0, 1'b1, 1'b0};
        vecs[9] = '{4, 8'h7, 8'h1, 1'b0, 8'h8, 1'b0, 1'b1};

        // ---- reset state, held across a clock edge ----
        iv4 = 1'b1; iv8 = 1'b1; iv1 = 1'b1;
        a4 = 4'h5; b4 = 4'h2;
        @(posedge clk); #1;
        check("rst_s4_q",   64'(s4_q),    64'h0);
        check("rst_cout4_q", 64'(cout4_q), 64'h0);
        check("rst_ovf4_q", 64'(ovf4_q),  64'h0);
        check("rst_ov4",    64'(ov4),     64'h0);
        check("rst_ov8",    64'(ov8),     64'h0);
        check("rst_ov1",    64'(ov1),     64'h0);
        check("rst_s8_q",   64'(s8_q),    64'h0);
        iv4 = 1'b0; iv8 = 1'b0; iv1 = 1'b0;

        @(negedge clk);
        rst = 1'b1;

        // ---- table-driven combinational vectors ----
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].w == 1) begin
                a1 = vecs[i].a[0:0]; b1 = vecs[i].b[0:0]; cin1 = vecs[i].cin;
                #1;
                check($sformatf("w1_s[%0d]", i),    64'(s1),    64'(vecs[i].s[0:0]));
                check($sformatf("w1_cout[%0d]", i), 64'(cout1), 64'(vecs[i].cout));
                check($sformatf("w1_ovf[%0d]", i),  64'(ovf1),  64'(vecs[i].ovf));
            end else begin
                a4 = vecs[i].a[3:0]; b4 = vecs[i].b[3:0]; cin4 = vecs[i].cin;
                #1;
                check($sformatf("w4_s[%0d]", i),    64'(s4),    64'(vecs[i].s[3:0]));
                check($sformatf("w4_cout[%0d]", i), 64'(cout4), 64'(vecs[i].cout));
                check($sformatf("w4_ovf[%0d]", i),  64'(ovf4),  64'(vecs[i].ovf));
            end
        end

        // ---- all-ones/all-zeros boundaries at WIDTH=8 ----
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; #1;
        check("w8_ones_s", 64'(s8), 64'hFF);
        check("w8_ones_c", 64'(cout8), 64'h1);
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; #1;
        check("w8_zero_s", 64'(s8), 64'h0);
        check("w8_zero_c", 64'(cout8), 64'h0);

        // ---- registered path, WIDTH=4 ----
        @(negedge clk);
        a4 = 4'd3; b4 = 4'd4; cin4 = 1'b0; iv4 = 1'b1;
        @(posedge clk); #1;
        check("reg_s4_q",   64'(s4_q),    64'd7);
        check("reg_ov4",    64'(ov4),     64'd1);
        check("reg_cout4_q", 64'(cout4_q), 64'd0);
        check("reg_ovf4_q", 64'(ovf4_q),  64'd0);

        @(negedge clk);
        a4 = 4'd1; iv4 = 1'b0;              // new operands, but not valid
        @(posedge clk); #1;
        check("hold_s4_q", 64'(s4_q), 64'd7);
        check("hold_ov4",  64'(ov4),  64'd0);

        // ---- asynchronous reset between edges ----
        @(negedge clk);
        a4 = 4'd3; b4 = 4'd4; iv4 = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_ov4", 64'(ov4), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_s4_q",   64'(s4_q),    64'd0);
        check("arst_cout4_q", 64'(cout4_q), 64'd0);
        check("arst_ovf4_q", 64'(ovf4_q),  64'd0);
        check("arst_ov4",    64'(ov4),     64'd0);
        a4 = 4'd5; #1;
        check("arst_comb_s4", 64'(s4), 64'd9);
        // A valid input at an edge during reset must not be captured.
        @(posedge clk); #1;
        check("arst_hold_s4_q", 64'(s4_q), 64'd0);
        check("arst_hold_ov4",  64'(ov4),  64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_s4_q", 64'(s4_q), 64'd9);
        check("post_rst_ov4",  64'(ov4),  64'd1);
        iv4 = 1'b0;

        // ---- random traffic on WIDTH=8, combinational + registered ----
        exp_s8_q = s8_q; exp_c8_q = cout8_q; exp_o8_q = ovf8_q; exp_v8 = ov8;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            ta = $urandom_range(0, 255);
            tb = $urandom_range(0, 255);
            tc = $urandom_range(0, 1);
            nxt_iv = 1'($urandom_range(0, 1));
            a8 = ta[7:0]; b8 = tb[7:0]; cin8 = tc[0]; iv8 = nxt_iv;
            #1;
            tot = ref_total(ta, tb, tc);
            check("rnd_s8",    64'(s8),    64'(tot & 32'hFF));
            check("rnd_cout8", 64'(cout8), 64'((tot >> 8) & 32'h1));
            check("rnd_ovf8",  64'(ovf8),  64'(ref_ovf(ta, tb, tc, 8)));
            if (nxt_iv) begin
                exp_s8_q = tot[7:0];
                exp_c8_q = tot[8];
                exp_o8_q = ref_ovf(ta, tb, tc, 8);
            end
            exp_v8 = nxt_iv;
            @(posedge clk); #1;
            check("rnd_s8_q",    64'(s8_q),    64'(exp_s8_q));
            check("rnd_cout8_q", 64'(cout8_q), 64'(exp_c8_q));
            check("rnd_ovf8_q",  64'(ovf8_q),  64'(exp_o8_q));
            check("rnd_ov8",     64'(ov8),     64'(exp_v8));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_adder

// File: doc/adder.md
Name: adder

Overview:
- Parameterised binary adder: A + B + carry-in, producing sum and carry-out.
- Combinational outputs s/cout are valid in the same cycle as the inputs. This path is the MIPS datapath building block; at WIDTH=1 it is a full adder.
- A registered copy of the result (s_q, cout_q, ovf_q) with a valid flag is also provided for pipelined consumers.
- Built as a ripple chain of 1-bit full-adder cells.

Parameters:
- WIDTH, 1, operand/sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock; used only by the registered copy.
- rst  input  1  asynchronous, active-low reset; the port name follows the codebase, the polarity is low-active.
- a  input  WIDTH  operand A, unsigned/two's-complement agnostic.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- in_valid  input  1  qualifies a/b/cin for the registered path.
- s  output  WIDTH  combinational sum, (a+b+cin) mod 2^WIDTH.
- cout  output  1  combinational carry-out, bit WIDTH of a+b+cin.
- ovf  output  1  combinational signed overflow: carry into MSB XOR cout.
- s_q  output  WIDTH  registered sum.
- cout_q  output  1  registered carry-out.
- ovf_q  output  1  registered overflow.
- out_valid  output  1  registered in_valid.

Behaviour:
- Combinational path (s, cout, ovf):
  - Pure function of a, b, cin; zero latency; independent of clk and rst.
  - Must settle within the same cycle; no latches.
- Arithmetic:
  - Full (WIDTH+1)-bit sum {cout, s} = a + b + cin, with no truncation of the carry.
  - Per bit i: s[i] = a[i]^b[i]^c[i]; c[i+1] = (a[i]&b[i]) | (c[i]&(a[i]^b[i])); c[0] = cin; cout = c[WIDTH].
- Overflow:
  - ovf = c[WIDTH-1] ^ c[WIDTH].
  - At WIDTH=1, c[0]=cin, so ovf = cin ^ cout.
- Registered path:
  - On each rising clk while rst is high, in_valid=1 captures s→s_q, cout→cout_q, ovf→ovf_q, and sets out_valid=1.
  - In_valid=0 holds s_q/cout_q/ovf_q and clears out_valid to 0.
  - Latency is 1 cycle.
- Reset:
  - rst low asynchronously forces s_q=0, cout_q=0, ovf_q=0, out_valid=0, immediately and regardless of clk.
  - Deassertion is synchronous to clk; the first capture occurs at the first rising edge with rst high.
  - Reset mid-operation discards any pending capture.
  - Combinational outputs are unaffected by reset.
- Boundaries:
  - All-ones + all-ones + 1 gives s=all-ones, cout=1.
  - All-zeros + 0 gives s=0, cout=0.
- X-propagation: any X/Z on inputs may propagate to outputs; there is no X-masking.

Decomposition:
- Shared package adder_pkg: default WIDTH constant (ADDER_WIDTH_DEFAULT=1) and a function computing the reference {cout,s} for benches.
- One sub-module, full_adder_cell (a, b, cin → s, cout), instantiated WIDTH times in a generate loop.
- Carry vector c[WIDTH:0] is internal to adder.

Test Plan:
- WIDTH=1, exhaustive 8 vectors of (a,b,cin):
  - 000→s0 c0
  - 001→s1 c0
  - 010→s1 c0
  - 011→s0 c1
  - 100→s1 c0
  - 101→s0 c1
  - 110→s0 c1
  - 111→s1 c1
- WIDTH=4, a=4'hF, b=4'h0, cin=1 → s=4'h0, cout=1, ovf=0; a=4'h7, b=4'h1, cin=0 → s=4'h8, cout=0, ovf=1.
- Registered path, WIDTH=4:
  - a=3, b=4, cin=0, in_valid=1 at edge N → s_q=7, out_valid=1 after edge N.
  - in_valid=0 at edge N+1 → s_q stays 7, out_valid=0.
- Async reset: drive rst low between clock edges with s_q=7 → s_q, cout_q, ovf_q, out_valid go 0 immediately; s still tracks inputs combinationally.
- WIDTH=8, 1000 random (a,b,cin) → {cout,s} matches the package reference function; ovf matches the signed-overflow definition.
